ram_burst_ctrl: RTL
===================

Name: ram_burst_ctrl

Overview:
Burst access sequencer that sits directly upstream of the 8-word RAM (RAM8) and drives its in/address/load pins. It accepts burst commands (start address plus length) and streams write data into the RAM or streams read data out of it. All three streams use valid/ready handshakes. It consumes the RAM's combinational read port and registers read data toward a downstream consumer.

Parameters:
DATA_W, 16, word width; matches the RAM data width
ADDR_W, 3, RAM address width; depth = 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  ADDR_W  burst length minus 1 (0 → 1 word, 7 → 8 words)
wr_data  input  DATA_W  write word
wr_valid  input  1  write word offered
wr_ready  output  1  write word accepted
rd_data  output  DATA_W  read word (registered)
rd_valid  output  1  read word present
rd_ready  input  1  downstream accepts read word
ram_in  output  DATA_W  to RAM in
ram_address  output  ADDR_W  to RAM address
ram_load  output  1  to RAM load
ram_out  input  DATA_W  from RAM out (combinational read of ram_address)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - rd_valid=0, rd_data=0, done=0.
  - Internal address and count = 0.
  - All outputs go to their IDLE values: cmd_ready=1, wr_ready=0, ram_load=0, ram_address=0, ram_in=0.
- Reset asserted mid-burst aborts the burst. A partially written burst leaves the already-written RAM words intact. No done pulse is issued.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr=cmd_addr and cnt=cmd_len.
  - Go to WRITE if cmd_write=1, else READ.
  - cmd_ready=0 in all other states.
- WRITE:
  - wr_ready=1, ram_address=addr, ram_in=wr_data.
  - ram_load=wr_valid (combinational, same cycle). The RAM captures the word at that clock edge.
  - Each accepted word: addr=addr+1 (wraps 7→0, modulo 2**ADDR_W). If cnt==0 go to DONE, else cnt=cnt-1.
  - wr_valid low: stall, no load, no state change.
- READ:
  - ram_address=addr, ram_load=0.
  - When (!rd_valid || rd_ready): rd_data<=ram_out, rd_valid<=1, addr<=addr+1 (wrapping).
  - If cnt==0 go to DRAIN, else cnt=cnt-1.
  - Otherwise hold: rd_data stable while rd_valid&&!rd_ready.
- DRAIN: wait until rd_valid&&rd_ready, clear rd_valid, go to DONE.
- Read side outside READ/DRAIN: a word accepted (rd_valid&&rd_ready) clears rd_valid.
- Latency:
  - Read: first word appears one cycle after command acceptance. Throughput is 1 word/cycle with rd_ready held high.
  - Write: first write can occur the cycle after command acceptance.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready stays 0 during DONE, so back-to-back commands incur a 1-cycle gap.
- Wrap-around: a burst from addr 6 with len 7 (8 words) touches 6,7,0,1,…,5. This is legal with no error.
- Outputs outside WRITE: ram_in=0 and ram_load=0 whenever state≠WRITE.
- Out-of-state inputs: wr_valid in non-WRITE states and cmd_valid in non-IDLE states are ignored.

Optional Feature:
Macro RBC_STATS_EN.
- Defined: adds output port burst_count [7:0]. It resets to 0 and increments by 1 on each done pulse, wrapping 255→0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then write burst addr=0 len=7 with wr_data 0x1000..0x1007, wr_valid held high → ram_load high 8 consecutive cycles at addresses 0..7, then one done pulse, then cmd_ready=1.
2. Following test 1, read burst addr=0 len=7 with rd_ready=1 → rd_data 0x1000..0x1007 on 8 consecutive cycles, starting 1 cycle after command acceptance; done pulses once after the last word is accepted.
3. Write burst addr=6 len=3 with data 0xA,0xB,0xC,0xD, then read addr=6 len=3 → writes hit addresses 6,7,0,1; read returns 0xA,0xB,0xC,0xD.
4. Read burst len=2 with rd_ready toggled 1,0,0,1,1 → rd_data holds while stalled, no word is dropped or duplicated, and 3 words are received in order.
5. Write burst len=3; deassert rst_n after 2 words are written → outputs immediately reach their reset values with no done pulse; a later read shows the 2 written words, and the other locations are unchanged.
6. With RBC_STATS_EN defined, run 3 bursts → burst_count=3. Without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of an 8-word RAM: streams write words in or registered read words out.
// Optional RBC_STATS_EN adds burst_count, a wrapping count of completed bursts.
module ram_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
`ifdef RBC_STATS_EN
    output logic [7:0]        burst_count,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_take;

    assign rd_take = rd_valid_q && rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        // A consumed read word frees the output register unless READ refills it below
        if (rd_take) begin
            rd_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - ADDR_W'(1);
                    end
                end
            end
            S_READ: begin
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d  = ram_out;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q - ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (rd_take) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        wr_ready    = (state_q == S_WRITE);
        ram_load    = (state_q == S_WRITE) && wr_valid;
        ram_in      = (state_q == S_WRITE) ? wr_data : '0;
        ram_address = ((state_q == S_WRITE) || (state_q == S_READ)) ? addr_q : '0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        rd_data     = rd_data_q;
        rd_valid    = rd_valid_q;
    end

`ifdef RBC_STATS_EN
    logic [7:0] burst_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_count_q <= '0;
        end else if (state_q == S_DONE) begin
            burst_count_q <= burst_count_q + 8'd1;
        end
    end

    assign burst_count = burst_count_q;
`endif

endmodule
